// File: rtl/combi_sweep_ctrl.sv
// combi_sweep_ctrl
// Steps a 3-input combinational block through vectors 0..7 in ascending order.
// Each vector is held for DWELL cycles, and then y is captured into a truth table.
// At the end of the sweep the table is compared against the expected word that
// was latched at start, and pass / fail_idx are reported with a one-cycle done pulse.
// The a/b/c outputs come straight from the vector index register, so they are
// registered. The index is parked at 0 whenever the block is not settling.

module combi_sweep_ctrl #(
    parameter int unsigned DWELL = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic [7:0] exp_tt_i,
    input  logic       y_i,
    output logic       a_o,
    output logic       b_o,
    output logic       c_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o,
    output logic [7:0] tt_o,
    output logic [2:0] fail_idx_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2
    } state_t;

    // Last dwell count value, on which y is sampled.
    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 32'd1);

    state_t     state_q;
    logic [2:0] idx_q;
    logic [7:0] cnt_q;
    logic [7:0] work_q;
    logic [7:0] exp_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic [7:0] tt_q;
    logic [2:0] fail_idx_q;

    logic [7:0] work_d;
    logic       pass_d;
    logic [2:0] fail_idx_d;
    logic       dwell_end_s;

    // Position of the lowest set bit, or 0 when no bit is set.
    function automatic logic [2:0] lowest_set(input logic [7:0] vec);
        logic [2:0] pos;
        pos = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) begin
                pos = 3'(i);
            end
        end
        return pos;
    endfunction

    // Next-state values: the table with y merged in, and the result of comparing it against the expected word.
    always_comb begin
        work_d         = work_q;
        work_d[idx_q]  = y_i;
        dwell_end_s    = (cnt_q == DWELL_LAST);
        pass_d         = (work_q == exp_q);
        fail_idx_d     = lowest_set(work_q ^ exp_q);
    end

    // Sweep FSM. All outputs are registered here, and done is a single-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= 3'd0;
            cnt_q      <= 8'd0;
            work_q     <= 8'h00;
            exp_q      <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            tt_q       <= 8'h00;
            fail_idx_q <= 3'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        exp_q   <= exp_tt_i;
                        work_q  <= 8'h00;
                        idx_q   <= 3'd0;
                        cnt_q   <= 8'd0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SETTLE;
                    end else begin
                        idx_q   <= 3'd0;
                        busy_q  <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (abort_i) begin
                        idx_q   <= 3'd0;
                        cnt_q   <= 8'd0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (dwell_end_s) begin
                        work_q <= work_d;
                        cnt_q  <= 8'd0;
                        if (idx_q == 3'd7) begin
                            // Vector 7 is done, so park the inputs at 000 for the check cycle.
                            idx_q   <= 3'd0;
                            state_q <= ST_CHECK;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_CHECK: begin
                    if (abort_i) begin
                        // The aborted sweep leaves the previous results untouched.
                        idx_q   <= 3'd0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        tt_q       <= work_q;
                        pass_q     <= pass_d;
                        fail_idx_q <= pass_d ? 3'd0 : fail_idx_d;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    idx_q   <= 3'd0;
                    cnt_q   <= 8'd0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign a_o        = idx_q[2];
    assign b_o        = idx_q[1];
    assign c_o        = idx_q[0];
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign pass_o     = pass_q;
    assign tt_o       = tt_q;
    assign fail_idx_o = fail_idx_q;

endmodule

// File: tb/tb_combi_sweep_ctrl.sv
// Testbench for combi_sweep_ctrl. The datapath is modelled as a truth-table lookup.
// Expected results come from the sweep rules: vector i is held for DWELL cycles,
// the captured table equals the model table, and the lowest mismatch is found by scanning upward.
// Two instances are used: DWELL = 3 and DWELL = 1.

module tb_combi_sweep_ctrl;

    localparam int D3     = 3;
    localparam int D1     = 1;
    localparam int SWEEP3 = 8 * D3 + 1;
    localparam int SWEEP1 = 8 * D1 + 1;

    logic clk = 1'b0;
    logic rst_n;

    logic       start3, abort3, y3, a3, b3, c3, busy3, done3, pass3;
    logic [7:0] exp3, tt3, model3;
    logic [2:0] fidx3;

    logic       start1, abort1, y1, a1, b1, c1, busy1, done1, pass1;
    logic [7:0] exp1, tt1, model1;
    logic [2:0] fidx1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [2:0] obs_abc  [0:63];
    logic       obs_busy [0:63];
    logic       obs_done [0:63];
    int         done_k;
    logic [7:0] done_tt;
    logic       done_pass;
    logic [2:0] done_fidx;

    always #5 clk = ~clk;

    assign y3 = model3[{a3, b3, c3}];
    assign y1 = model1[{a1, b1, c1}];

    combi_sweep_ctrl #(.DWELL(D3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start_i(start3), .abort_i(abort3),
        .exp_tt_i(exp3), .y_i(y3), .a_o(a3), .b_o(b3), .c_o(c3),
        .busy_o(busy3), .done_o(done3), .pass_o(pass3), .tt_o(tt3),
        .fail_idx_o(fidx3)
    );

    combi_sweep_ctrl #(.DWELL(D1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start1), .abort_i(abort1),
        .exp_tt_i(exp1), .y_i(y1), .a_o(a1), .b_o(b1), .c_o(c1),
        .busy_o(busy1), .done_o(done1), .pass_o(pass1), .tt_o(tt1),
        .fail_idx_o(fidx1)
    );

    // Reference: the lowest index where the captured and expected tables differ, or 0 when they agree.
    function automatic logic [2:0] ref_fail_idx(input logic [7:0] got, input logic [7:0] expv);
        for (int i = 0; i < 8; i++) begin
            if (got[i] != expv[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    // Run one sweep on the DWELL=3 instance and record outputs at every negedge after the start edge.
    task automatic do_sweep3(input logic [7:0] model, input logic [7:0] expv, input bit inject);
        @(negedge clk);
        model3 = model;
        exp3   = expv;
        start3 = 1'b1;
        @(posedge clk);
        #1;
        start3 = 1'b0;
        exp3   = 8'($urandom);
        done_k = -1;
        for (int k = 0; k <= 8 * D3 + 2; k++) begin
            @(negedge clk);
            obs_abc[k]  = {a3, b3, c3};
            obs_busy[k] = busy3;
            obs_done[k] = done3;
            if (done3 && done_k < 0) begin
                done_k    = k;
                done_tt   = tt3;
                done_pass = pass3;
                done_fidx = fidx3;
            end
            start3 = inject && (k < 8 * D3) && ($urandom_range(0, 2) == 0);
        end
        start3 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start3 = 1'b0; abort3 = 1'b0; exp3 = 8'h00; model3 = 8'h00;
        start1 = 1'b0; abort1 = 1'b0; exp1 = 8'h00; model1 = 8'h00;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({a3, b3, c3, busy3, done3, pass3, tt3, fidx3} !== 17'd0) begin
            n_bad++;
            $display("FAIL reset3: got abc=%b busy=%b done=%b pass=%b tt=%h fidx=%0d, all expected 0",
                     {a3, b3, c3}, busy3, done3, pass3, tt3, fidx3);
        end
        n_cmp++;
        if ({a1, b1, c1, busy1, done1, pass1, tt1, fidx1} !== 17'd0) begin
            n_bad++;
            $display("FAIL reset1: got abc=%b busy=%b done=%b pass=%b tt=%h fidx=%0d, all expected 0",
                     {a1, b1, c1}, busy1, done1, pass1, tt1, fidx1);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_and3();
        do_sweep3(8'h80, 8'h80, 1'b0);
        n_cmp++;
        if (done_k !== SWEEP3) begin n_bad++; $display("FAIL and3_latency: got %0d expected %0d", done_k, SWEEP3); end
        n_cmp++;
        if (done_pass !== 1'b1) begin n_bad++; $display("FAIL and3_pass: got %b expected 1", done_pass); end
        n_cmp++;
        if (done_tt !== 8'h80) begin n_bad++; $display("FAIL and3_tt: got %h expected 80", done_tt); end
        n_cmp++;
        if (done_fidx !== 3'd0) begin n_bad++; $display("FAIL and3_fidx: got %0d expected 0", done_fidx); end
        n_cmp++;
        if (obs_busy[SWEEP3] !== 1'b0) begin n_bad++; $display("FAIL and3_busy_done: got %b expected 0", obs_busy[SWEEP3]); end
    endtask

    task automatic test_xor3();
        logic [7:0] exps [0:2];
        exps[0] = 8'h96; exps[1] = 8'h97; exps[2] = 8'h16;
        for (int t = 0; t < 3; t++) begin
            do_sweep3(8'h96, exps[t], 1'b0);
            n_cmp++;
            if (done_tt !== 8'h96) begin n_bad++; $display("FAIL xor3_tt[%0d]: got %h expected 96", t, done_tt); end
            n_cmp++;
            if (done_pass !== (t == 0)) begin n_bad++; $display("FAIL xor3_pass[%0d]: got %b expected %b", t, done_pass, (t == 0)); end
            n_cmp++;
            if (done_fidx !== ((t == 2) ? 3'd7 : 3'd0)) begin
                n_bad++;
                $display("FAIL xor3_fidx[%0d]: got %0d expected %0d", t, done_fidx, (t == 2) ? 7 : 0);
            end
        end
    endtask

    task automatic test_vector_trace();
        logic [7:0] model;
        logic [7:0] expv;
        logic [2:0] e_abc;
        model = 8'($urandom);
        expv  = 8'($urandom);
        do_sweep3(model, expv, 1'b1);
        for (int k = 0; k <= 8 * D3 + 2; k++) begin
            e_abc = (k < 8 * D3) ? 3'(k / D3) : 3'd0;
            n_cmp++;
            if (obs_abc[k] !== e_abc) begin n_bad++; $display("FAIL trace_abc[%0d]: got %0d expected %0d", k, obs_abc[k], e_abc); end
            n_cmp++;
            if (obs_busy[k] !== (k <= 8 * D3)) begin n_bad++; $display("FAIL trace_busy[%0d]: got %b expected %b", k, obs_busy[k], (k <= 8 * D3)); end
            n_cmp++;
            if (obs_done[k] !== (k == SWEEP3)) begin n_bad++; $display("FAIL trace_done[%0d]: got %b expected %b", k, obs_done[k], (k == SWEEP3)); end
        end
        n_cmp++;
        if (done_tt !== model) begin n_bad++; $display("FAIL trace_tt: got %h expected %h", done_tt, model); end
        n_cmp++;
        if (done_pass !== (model == expv)) begin n_bad++; $display("FAIL trace_pass: got %b expected %b", done_pass, (model == expv)); end
        n_cmp++;
        if (done_fidx !== ref_fail_idx(model, expv)) begin
            n_bad++;
            $display("FAIL trace_fidx: got %0d expected %0d", done_fidx, ref_fail_idx(model, expv));
        end
    endtask

    task automatic test_random();
        logic [7:0] model;
        logic [7:0] expv;
        for (int t = 0; t < 8; t++) begin
            model = 8'($urandom);
            expv  = ($urandom_range(0, 1) == 0) ? model : (model ^ 8'($urandom));
            do_sweep3(model, expv, 1'b0);
            n_cmp++;
            if (done_k !== SWEEP3) begin n_bad++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", t, done_k, SWEEP3); end
            n_cmp++;
            if (done_tt !== model) begin n_bad++; $display("FAIL rand_tt[%0d]: got %h expected %h", t, done_tt, model); end
            n_cmp++;
            if (done_pass !== (model == expv)) begin n_bad++; $display("FAIL rand_pass[%0d]: got %b expected %b", t, done_pass, (model == expv)); end
            n_cmp++;
            if (done_fidx !== ref_fail_idx(model, expv)) begin
                n_bad++;
                $display("FAIL rand_fidx[%0d]: got %0d expected %0d", t, done_fidx, ref_fail_idx(model, expv));
            end
        end
    endtask

    task automatic test_abort();
        bit seen_done;
        do_sweep3(8'h80, 8'h80, 1'b0);
        @(negedge clk);
        model3 = 8'h96;
        exp3   = 8'h96;
        start3 = 1'b1;
        @(posedge clk);
        #1;
        start3 = 1'b0;
        repeat (10) @(negedge clk);
        abort3 = 1'b1;
        @(negedge clk);
        abort3 = 1'b0;
        n_cmp++;
        if (busy3 !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b expected 0", busy3); end
        n_cmp++;
        if ({a3, b3, c3} !== 3'd0) begin n_bad++; $display("FAIL abort_abc: got %0d expected 0", {a3, b3, c3}); end
        seen_done = done3;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done3) seen_done = 1'b1;
        end
        n_cmp++;
        if (seen_done !== 1'b0) begin n_bad++; $display("FAIL abort_no_done: got %b expected 0", seen_done); end
        n_cmp++;
        if (tt3 !== 8'h80) begin n_bad++; $display("FAIL abort_tt: got %h expected 80", tt3); end
        n_cmp++;
        if (pass3 !== 1'b1) begin n_bad++; $display("FAIL abort_pass: got %b expected 1", pass3); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        model3 = 8'h80;
        exp3   = 8'h80;
        start3 = 1'b1;
        @(posedge clk);
        #1;
        start3 = 1'b0;
        repeat (8) @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({a3, b3, c3, busy3, done3, pass3, tt3, fidx3} !== 17'd0) begin
            n_bad++;
            $display("FAIL midreset: got abc=%b busy=%b done=%b pass=%b tt=%h fidx=%0d, all expected 0",
                     {a3, b3, c3}, busy3, done3, pass3, tt3, fidx3);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_sweep3(8'h80, 8'h80, 1'b0);
        n_cmp++;
        if (done_k !== SWEEP3) begin n_bad++; $display("FAIL midreset_latency: got %0d expected %0d", done_k, SWEEP3); end
        n_cmp++;
        if (done_tt !== 8'h80) begin n_bad++; $display("FAIL midreset_tt: got %h expected 80", done_tt); end
    endtask

    task automatic test_back_to_back();
        int got;
        @(negedge clk);
        model1 = 8'h80;
        exp1   = 8'h80;
        start1 = 1'b1;
        for (int s = 0; s < 2; s++) begin
            @(posedge clk);
            #1;
            start1 = 1'b0;
            got = -1;
            for (int k = 0; k < 20 && got < 0; k++) begin
                @(negedge clk);
                if (done1) got = k;
            end
            n_cmp++;
            if (got !== SWEEP1) begin n_bad++; $display("FAIL b2b_latency[%0d]: got %0d expected %0d", s, got, SWEEP1); end
            n_cmp++;
            if (tt1 !== 8'h80) begin n_bad++; $display("FAIL b2b_tt[%0d]: got %h expected 80", s, tt1); end
            n_cmp++;
            if (busy1 !== 1'b0) begin n_bad++; $display("FAIL b2b_busy[%0d]: got %b expected 0", s, busy1); end
            // Restart in the done cycle itself.
            start1 = (s == 0);
        end
        start1 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_and3();
        test_xor3();
        test_vector_trace();
        test_random();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
